hud_seg_display: RTL and testbench

// Downstream consumer of the game controller's status outputs (score, health, lvl, fail, next_lvl).

---
 rtl/hud_seg_display.sv | 213 +++++++++++++++++++++
 tb/tb_hud_seg_display.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hud_seg_display.sv
// HUD display driver: picks one game status value, converts it to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit multiplexed
// 7-segment display with leading-zero blanking, level banner and game-over blink.
module hud_seg_display #(
  parameter int unsigned REFRESH_DIV     = 100_000,
  parameter int unsigned BLINK_DIV       = 25_000_000,
  parameter int unsigned LVL_SHOW_CYCLES = 200_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] score,
  input  logic [12:0] health,
  input  logic [12:0] lvl,
  input  logic        fail,
  input  logic        next_lvl,
  input  logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned RefW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlinkW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned BannerW = $clog2(LVL_SHOW_CYCLES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StShift  = 2'd2;
  localparam logic [1:0] StCommit = 2'd3;

  logic               next_lvl_q;
  logic [BannerW-1:0] banner_q, banner_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [RefW-1:0]    ref_q, ref_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         state_q, state_d;
  logic [12:0]        bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d, bcd_adj;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        disp_q, disp_d;
  logic               snap_hl_q, snap_hl_d;
  logic               disp_hl_q, disp_hl_d;
  logic [3:0]         an_d;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic [12:0]        src;
  logic               src_hl;
  logic               banner_on;
  logic [3:0]         digit;
  logic [3:0]         lz;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Banner countdown, blink phase and scan position next-state.
  always_comb begin
    banner_d    = banner_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    ref_d       = ref_q + 1'b1;
    idx_d       = idx_q;
    if (next_lvl && !next_lvl_q) begin
      banner_d = BannerW'(LVL_SHOW_CYCLES);
    end else if (banner_q != '0) begin
      banner_d = banner_q - 1'b1;
    end
    if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Source select: the banner overrides sel and forces the level.
  always_comb begin
    banner_on = (banner_q != '0);
    src_hl    = 1'b0;
    if (banner_on) begin
      src = lvl;
    end else begin
      case (sel)
        2'b01:   begin src = health; src_hl = 1'b1; end
        2'b10:   src = lvl;
        default: src = score;
      endcase
    end
  end

  // Double-dabble conversion FSM; disp only changes in COMMIT so digits never tear.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    snap_hl_d = snap_hl_q;
    disp_hl_d = disp_hl_q;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    case (state_q)
      StIdle: state_d = StLoad;
      StLoad: begin
        bin_d     = src;
        bcd_d     = '0;
        cnt_d     = '0;
        snap_hl_d = src_hl;
        state_d   = StShift;
      end
      StShift: begin
        bcd_d = (bcd_adj << 1) | {15'd0, bin_q[12]};
        bin_d = {bin_q[11:0], 1'b0};
        if (cnt_q == 4'd12) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        disp_d    = bcd_q;
        disp_hl_d = snap_hl_q;
        state_d   = StIdle;
      end
    endcase
  end

  // Digit drive for the current scan slot, with leading-zero and blink blanking.
  always_comb begin
    digit = disp_q[{idx_q, 2'b00} +: 4];
    lz[3] = (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    lz[0] = 1'b0;
    if (lz[idx_q] || (fail && blink_q)) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end
    seg_d = seg_code(digit);
    dp_d  = !((idx_q == 2'd0) && disp_hl_q);
  end

  // Timing state: edge detect, banner, blink and scan counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_lvl_q  <= 1'b0;
      banner_q    <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      ref_q       <= '0;
      idx_q       <= '0;
    end else begin
      next_lvl_q  <= next_lvl;
      banner_q    <= banner_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      ref_q       <= ref_d;
      idx_q       <= idx_d;
    end
  end

  // Conversion engine and committed display value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      snap_hl_q <= 1'b0;
      disp_hl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      snap_hl_q <= snap_hl_d;
      disp_hl_q <= disp_hl_d;
    end
  end

  // Registered display pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_hud_seg_display.sv
// Self-checking bench for hud_seg_display: scoreboard of expected display values
// checked by a monitor over full scan windows, plus blink, banner and reset checks.
module tb_hud_seg_display;

  localparam int REFRESH = 4;
  localparam int BLINK   = 16;
  localparam int LVLSHOW = 64;

  typedef struct {
    int val;
    bit hl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] score = '0;
  logic [12:0] health = '0;
  logic [12:0] lvl = '0;
  logic        fail = 1'b0;
  logic        next_lvl = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issued = 0;
  int   mon_done = 0;
  exp_t sb_q[$];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  hud_seg_display #(
    .REFRESH_DIV    (REFRESH),
    .BLINK_DIV      (BLINK),
    .LVL_SHOW_CYCLES(LVLSHOW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .score   (score),
    .health  (health),
    .lvl     (lvl),
    .fail    (fail),
    .next_lvl(next_lvl),
    .sel     (sel),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp, input int ctx);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (value %0d, cycle %0d)", name, act, exp, ctx, cyc);
    end
  endtask

  // Observe one full scan period and compare every slot against decimal digits of val.
  task automatic check_window(input int val, input bit hl);
    int seen [4];
    int dig [4];
    bit blank_exp [4];
    int nblank_obs;
    int nblank_exp;
    int k;
    int p;
    logic [3:0] m;
    nblank_obs = 0;
    nblank_exp = 0;
    p = 1;
    for (int j = 0; j < 4; j++) begin
      dig[j]       = (val / p) % 10;
      blank_exp[j] = (j != 0) && (val < p);
      seen[j]      = 0;
      if (blank_exp[j]) nblank_exp += REFRESH;
      p = p * 10;
    end
    for (int c = 0; c < 4 * REFRESH; c++) begin
      @(negedge clk);
      if (an == 4'b1111) begin
        nblank_obs++;
      end else begin
        k = -1;
        for (int j = 0; j < 4; j++) begin
          m = 4'b0001 << j;
          if (an == ~m) k = j;
        end
        chk("anode_onehot", int'(k >= 0), 1, val);
        if (k >= 0) begin
          seen[k]++;
          chk("seg_digit", int'(seg), int'(seg_tab[dig[k]]), val);
          chk("dp", int'(dp), (k == 0 && hl) ? 0 : 1, val);
        end
      end
    end
    for (int j = 0; j < 4; j++) chk("slot_count", seen[j], blank_exp[j] ? 0 : REFRESH, val);
    chk("blank_count", nblank_obs, nblank_exp, val);
  endtask

  // Push an expectation and hold inputs until the monitor has consumed it.
  task automatic issue(input int val, input bit hl);
    sb_q.push_back('{val: val, hl: hl});
    issued++;
    for (int i = 0; i < 400 && mon_done < issued; i++) @(negedge clk);
    if (mon_done < issued) chk("sb_timeout", mon_done, issued, val);
  endtask

  // Reference model: which value the display should show for a given sel.
  task automatic drive(input int s, input int h, input int l, input int sl);
    int v;
    @(negedge clk);
    score  = 13'(s);
    health = 13'(h);
    lvl    = 13'(l);
    sel    = 2'(sl);
    v = (sl == 1) ? h : (sl == 2) ? l : s;
    issue(v, sl == 1);
  endtask

  // Monitor: waits for the display to settle, then checks a whole scan.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        repeat (40) @(negedge clk);
        check_window(e.val, e.hl);
        mon_done++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, run, maxrun, p0, last3;
    bit seen3;
    repeat (3) @(negedge clk);
    chk("reset_an", int'(an), 4'b1111, 0);
    chk("reset_seg", int'(seg), 7'b1111111, 0);
    chk("reset_dp", int'(dp), 1, 0);
    rst_n = 1'b1;
    issue(0, 1'b0);

    drive(1234, 0, 0, 0);
    drive(8191, 0, 0, 0);
    drive(7, 0, 0, 0);
    drive(7, 100, 0, 1);
    drive(7, 100, 12, 2);
    drive(906, 100, 12, 3);
    drive(10, 5, 40, 1);
    for (int i = 0; i < 16; i++) begin
      drive($urandom_range(0, 8191) >> $urandom_range(0, 12),
            $urandom_range(0, 8191) >> $urandom_range(0, 12),
            $urandom_range(0, 8191) >> $urandom_range(0, 12), $urandom_range(0, 3));
    end

    // Game-over blink: 16 blank, 16 visible, repeating.
    drive(1234, 0, 0, 0);
    @(negedge clk);
    fail = 1'b1;
    nb = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 4'b1111) begin
        nb++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    chk("blink_blank_cycles", nb, 32, 1234);
    chk("blink_half_period", maxrun, BLINK, 1234);
    fail = 1'b0;
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an == 4'b1111) nb++;
    end
    chk("fail_release", nb, 0, 1234);

    // Level banner with a retrigger at cycle 40; the second edge is held high.
    drive(55, 0, 3, 0);
    @(negedge clk);
    next_lvl = 1'b1;
    p0 = cyc + 1;
    last3 = -1;
    seen3 = 1'b0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (cyc == p0) next_lvl = 1'b0;
      if (cyc == p0 + 39) next_lvl = 1'b1;
      if (an == 4'b1110 && seg == seg_tab[3]) begin
        last3 = cyc - p0;
        seen3 = 1'b1;
      end
    end
    chk("banner_shown", int'(seen3), 1, 3);
    chk("banner_extended", int'(last3 >= 100), 1, last3);
    chk("banner_ended", int'(last3 <= 140), 1, last3);
    issue(55, 1'b0);
    next_lvl = 1'b0;

    // Reset in the middle of a conversion.
    drive(1234, 0, 0, 0);
    repeat ($urandom_range(3, 12)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_an", int'(an), 4'b1111, 1234);
    chk("midreset_seg", int'(seg), 7'b1111111, 1234);
    chk("midreset_dp", int'(dp), 1, 1234);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postreset_an", int'(an), 4'b1110, 0);
    chk("postreset_seg", int'(seg), 7'b1000000, 0);
    issue(1234, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
